// File: rtl/demux8_stage.sv
// 1-to-8 registered demux: one-entry holding slot per lane, accept-to-out_valid latency 1 cycle.
// in_ready drops only when the addressed lane is full and not draining; other lanes keep draining.
// Defining DEMUX8_COUNT_EN adds per-lane drain counters on cnt_flat.
module demux8_stage #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [2:0]             in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [8*WIDTH-1:0]     out_data,
  output logic [7:0]             out_valid,
  input  logic [7:0]             out_ready
`ifdef DEMUX8_COUNT_EN
  ,
  output logic [8*CNT_WIDTH-1:0] cnt_flat
`endif
);

  logic [7:0]            slot_v_q, slot_v_d;
  logic [7:0][WIDTH-1:0] slot_d_q, slot_d_d;
  logic [7:0]            drain;
  logic                  wr_en;

  assign drain     = slot_v_q & out_ready;
  assign in_ready  = ~slot_v_q[in_sel] | out_ready[in_sel];
  assign wr_en     = in_valid & in_ready;
  assign out_valid = slot_v_q;
  assign out_data  = slot_d_q;

  // A refill overrides the drain of the same lane, so a full lane streams without bubbles.
  always_comb begin
    slot_v_d = slot_v_q & ~drain;
    slot_d_d = slot_d_q;
    if (wr_en) begin
      slot_v_d[in_sel] = 1'b1;
      slot_d_d[in_sel] = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_v_q <= '0;
      slot_d_q <= '0;
    end else begin
      slot_v_q <= slot_v_d;
      slot_d_q <= slot_d_d;
    end
  end

`ifdef DEMUX8_COUNT_EN
  logic [7:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      cnt_d[k] = cnt_q[k] + CNT_WIDTH'(drain[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_flat = cnt_q;
`else
  if (CNT_WIDTH < 1) begin : g_cnt_width_unused
  end
`endif

endmodule

// File: doc/demux8_stage.md
Name: demux8_stage

Overview:
- Registered 1-to-8 demultiplexing pipeline stage with valid/ready handshakes; the inverse of the 8-input select mux in the simple pipeline.
- Routes one producer's result (for example an execute/write-back result) to one of eight consumer lanes, chosen by a 3-bit selector.
- Each lane has its own one-entry holding register, so a stalled lane blocks only traffic addressed to that lane.

Parameters:
- WIDTH, 1, data width of the input and of each lane.
- CNT_WIDTH, 8, width of each per-lane transfer counter; used only when DEMUX8_COUNT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_data  input  WIDTH  payload.
- in_sel  input  3  destination lane; 3'b000 selects lane 0, through 3'b111 for lane 7.
- in_valid  input  1  the producer presents in_data/in_sel this cycle.
- in_ready  output  1  the stage accepts this cycle.
- out_data  output  8*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  8  lane k's slot holds data.
- out_ready  input  8  lane k's consumer takes the data this cycle.
- cnt_flat  output  8*CNT_WIDTH  present only with DEMUX8_COUNT_EN; lane k occupies bits [k*CNT_WIDTH +: CNT_WIDTH].

Behaviour:
- State: 8 slots, each a valid bit slot_v[k] and a data register slot_d[k]. out_valid[k] = slot_v[k] and out_data lane k = slot_d[k], both driven directly from registers.
- Reset (asynchronous, any cycle, including mid-transfer): all slot_v = 0, all slot_d = 0 and all counters = 0. An accept pending in the reset cycle is discarded.
- in_ready = ~slot_v[in_sel] | out_ready[in_sel]. It is combinational from in_sel and out_ready and does not depend on in_valid.
- Accept: when in_valid & in_ready, slot_d[in_sel] <= in_data and slot_v[in_sel] <= 1. Latency is exactly 1 cycle from accept to out_valid.
- Drain: when out_valid[k] & out_ready[k], slot_v[k] <= 0, unless lane k is refilled in the same cycle. In that case slot_v[k] stays 1 and slot_d[k] takes the new data.
- Full lane: if slot_v[in_sel] = 1 and out_ready[in_sel] = 0, then in_ready = 0, no slot changes, and the producer must hold in_data/in_sel stable.
- Other lanes drain independently every cycle, regardless of any input stall.
- Data holding: slot_d[k] changes only on accept. After a drain it keeps its last value while out_valid[k] = 0.
- At most one lane is written per cycle. Any number of lanes may drain in the same cycle.
- Consumer rule: out_data/out_valid for a lane stay stable while out_valid = 1 and out_ready = 0.
- Input ignored: in_valid = 0 leaves all slots unchanged except for drains.

Optional Feature:
- Macro: DEMUX8_COUNT_EN.
- Defined: port cnt_flat exists. There are eight CNT_WIDTH-bit counters; counter k increments by 1 on every lane-k drain (out_valid[k] & out_ready[k]). Counters wrap from all-ones to 0 and reset to 0.
- Not defined: no counters and no cnt_flat port. Behaviour is otherwise identical.

Test Plan:
- Reset then idle: in_valid = 0, rst pulsed mid-cycle -> out_valid = 8'h00 immediately; out_data all zeros; in_ready = 1 for every in_sel.
- Single route: WIDTH = 8, in_data = 8'hA5, in_sel = 3, in_valid = 1 for one cycle with out_ready = 8'hFF -> next cycle out_valid = 8'h08 and lane 3 = 8'hA5; the cycle after, out_valid = 8'h00 and lane 3 still reads 8'hA5.
- Lane backpressure: out_ready[5] = 0; send 8'h11 then 8'h22 to lane 5 -> the first is accepted; in_ready = 0 while in_sel = 5; lane 5 holds 8'h11. Meanwhile 8'h33 sent to lane 2 is accepted and appears on lane 2 the next cycle.
- Drain and refill the same cycle: lane 5 holds 8'h11; raise out_ready[5] while 8'h22 is presented to lane 5 -> in_ready = 1; next cycle out_valid[5] = 1 and lane 5 = 8'h22, with no bubble.
- Reset mid-operation: lanes 0, 4 and 7 valid; assert rst during an accept to lane 1 -> out_valid = 8'h00; lane 1 is not written; after release, the first accept behaves normally.
- With DEMUX8_COUNT_EN, CNT_WIDTH = 2: five drains on lane 6 -> counter 6 reads 1 after wrapping; all other counters read 0.
